// File: rtl/recv_pkg.sv
// Shared constants and types for the package-value receiver.
package recv_pkg;

    localparam logic [7:0]  FOO       = 8'd3;
    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned DATA_W    = 8;

    typedef enum logic {
        RUN    = 1'b0,
        REPORT = 1'b1
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Counter that adds 0..2 per cycle and sticks at all-ones; clear has priority.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic [1:0]   inc,
    output logic [W-1:0] count
);

    localparam int unsigned SW = W + 1;

    logic [W:0]   sum;
    logic [W-1:0] count_d;

    always_comb begin
        sum     = {1'b0, count} + SW'(inc);
        count_d = sum[W] ? {W{1'b1}} : sum[W-1:0];
        if (clear) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_d;
        end
    end

endmodule

// File: rtl/pkg_value_receiver.sv
// Checks sample pairs against FOO, keeps running statistics and reports
// pass/fail once per WINDOW accepted pairs.
module pkg_value_receiver
    import recv_pkg::*;
#(
    parameter int unsigned WINDOW = 8,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [DATA_W-1:0] in_data2,
    input  logic              clear,
    output logic              report_valid,
    input  logic              report_ready,
    output logic              report_ok,
    output logic [DATA_W-1:0] report_bad,
    output logic [CNT_W-1:0]  match_count,
    output logic [CNT_W-1:0]  mismatch_count,
    output logic              sticky_err
);

    localparam int unsigned WC_W = 8;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   win_cnt_q, win_cnt_d;
    logic              win_err_q, win_err_d;
    logic              in_ready_d;
    logic              report_valid_d;
    logic              report_ok_d;
    logic [DATA_W-1:0] report_bad_d;
    logic              sticky_d;

    logic              accept;
    logic              m1, m2, mis_any;
    logic [1:0]        inc_match, inc_mis;

    assign accept    = in_valid & in_ready;
    assign m1        = (in_data1 == FOO);
    assign m2        = (in_data2 == FOO);
    assign mis_any   = ~(m1 & m2);
    assign inc_match = accept ? ({1'b0, m1} + {1'b0, m2}) : 2'd0;
    assign inc_mis   = accept ? ({1'b0, ~m1} + {1'b0, ~m2}) : 2'd0;

    sat_counter #(.W(CNT_W)) u_match_cnt (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .inc   (inc_match),
        .count (match_count)
    );

    sat_counter #(.W(CNT_W)) u_mismatch_cnt (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .inc   (inc_mis),
        .count (mismatch_count)
    );

    // Next-state and registered-output values
    always_comb begin
        state_d        = state_q;
        win_cnt_d      = win_cnt_q;
        win_err_d      = win_err_q;
        in_ready_d     = in_ready;
        report_valid_d = report_valid;
        report_ok_d    = report_ok;
        report_bad_d   = report_bad;
        sticky_d       = sticky_err | (accept & mis_any);
        if (clear) begin
            sticky_d = 1'b0;
        end

        unique case (state_q)
            RUN: begin
                in_ready_d = 1'b1;
                if (accept) begin
                    win_cnt_d = win_cnt_q + WC_W'(1);
                    win_err_d = win_err_q | mis_any;
                    // Only the first mismatch of the window is kept; lane 1 wins
                    if (!win_err_q && mis_any) begin
                        report_bad_d = m1 ? in_data2 : in_data1;
                    end
                    if (win_cnt_q == WC_W'(WINDOW - 1)) begin
                        state_d        = REPORT;
                        in_ready_d     = 1'b0;
                        report_valid_d = 1'b1;
                        report_ok_d    = ~(win_err_q | mis_any);
                    end
                end
            end
            REPORT: begin
                in_ready_d = 1'b0;
                if (report_ready) begin
                    state_d        = RUN;
                    in_ready_d     = 1'b1;
                    win_cnt_d      = '0;
                    win_err_d      = 1'b0;
                    report_bad_d   = '0;
                    report_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            win_cnt_q    <= '0;
            win_err_q    <= 1'b0;
            in_ready     <= 1'b1;
            report_valid <= 1'b0;
            report_ok    <= 1'b0;
            report_bad   <= '0;
            sticky_err   <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_cnt_q    <= win_cnt_d;
            win_err_q    <= win_err_d;
            in_ready     <= in_ready_d;
            report_valid <= report_valid_d;
            report_ok    <= report_ok_d;
            report_bad   <= report_bad_d;
            sticky_err   <= sticky_d;
        end
    end

endmodule

// File: tb/tb_pkg_value_receiver.sv
// Directed bench for pkg_value_receiver; a second instance with 4-bit counters covers saturation.
module tb_pkg_value_receiver;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data1 = 8'd0;
    logic [7:0]  in_data2 = 8'd0;
    logic        clear = 1'b0;
    logic        report_ready = 1'b0;

    logic        in_ready, report_valid, report_ok, sticky_err;
    logic [7:0]  report_bad;
    logic [15:0] match_count, mismatch_count;

    logic        s_in_ready, s_report_valid, s_report_ok, s_sticky_err;
    logic [7:0]  s_report_bad;
    logic [3:0]  s_match_count, s_mismatch_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    pkg_value_receiver #(.WINDOW(8), .CNT_W(16)) dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data1       (in_data1),
        .in_data2       (in_data2),
        .clear          (clear),
        .report_valid   (report_valid),
        .report_ready   (report_ready),
        .report_ok      (report_ok),
        .report_bad     (report_bad),
        .match_count    (match_count),
        .mismatch_count (mismatch_count),
        .sticky_err     (sticky_err)
    );

    pkg_value_receiver #(.WINDOW(8), .CNT_W(4)) dut_sat (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (s_in_ready),
        .in_data1       (in_data1),
        .in_data2       (in_data2),
        .clear          (clear),
        .report_valid   (s_report_valid),
        .report_ready   (report_ready),
        .report_ok      (s_report_ok),
        .report_bad     (s_report_bad),
        .match_count    (s_match_count),
        .mismatch_count (s_mismatch_count),
        .sticky_err     (s_sticky_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one pair for a single edge; caller guarantees in_ready is high.
    task automatic send(input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        in_data1 = a;
        in_data2 = b;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    initial begin
        // Reset values
        #12;
        check("rst_in_ready",     32'(in_ready), 32'd1);
        check("rst_report_valid", 32'(report_valid), 32'd0);
        check("rst_report_ok",    32'(report_ok), 32'd0);
        check("rst_report_bad",   32'(report_bad), 32'd0);
        check("rst_match",        32'(match_count), 32'd0);
        check("rst_mismatch",     32'(mismatch_count), 32'd0);
        check("rst_sticky",       32'(sticky_err), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Clean window, report consumed immediately
        report_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(8'd3, 8'd3);
        check("w1_report_valid", 32'(report_valid), 32'd1);
        check("w1_report_ok",    32'(report_ok), 32'd1);
        check("w1_report_bad",   32'(report_bad), 32'd0);
        check("w1_match",        32'(match_count), 32'd16);
        check("w1_mismatch",     32'(mismatch_count), 32'd0);
        check("w1_in_ready",     32'(in_ready), 32'd0);
        check("sat_match_w1",    32'(s_match_count), 32'd15);
        @(posedge clock); #1;
        check("w1_valid_drop",   32'(report_valid), 32'd0);
        check("w1_in_ready_back", 32'(in_ready), 32'd1);
        report_ready = 1'b0;

        // Window with mismatches on pair 4 (lane 2) and pair 6 (both lanes)
        send(8'd3, 8'd3);
        check("sat_match_stuck", 32'(s_match_count), 32'd15);
        send(8'd3, 8'd3);
        send(8'd3, 8'd3);
        check("w2_sticky_pre",   32'(sticky_err), 32'd0);
        send(8'd3, 8'h55);
        check("w2_sticky_set",   32'(sticky_err), 32'd1);
        send(8'd3, 8'd3);
        send(8'h77, 8'h66);
        send(8'd3, 8'd3);
        send(8'd3, 8'd3);
        check("w2_report_valid", 32'(report_valid), 32'd1);
        check("w2_report_ok",    32'(report_ok), 32'd0);
        check("w2_report_bad",   32'(report_bad), 32'h55);
        check("w2_mismatch",     32'(mismatch_count), 32'd3);
        check("w2_match",        32'(match_count), 32'd29);
        check("w2_sticky",       32'(sticky_err), 32'd1);
        check("sat_mismatch",    32'(s_mismatch_count), 32'd3);

        // Backpressure: report held, offered pairs ignored
        in_valid = 1'b1;
        in_data1 = 8'd3;
        in_data2 = 8'd3;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            check("bp_in_ready",     32'(in_ready), 32'd0);
            check("bp_report_valid", 32'(report_valid), 32'd1);
            check("bp_report_bad",   32'(report_bad), 32'h55);
            check("bp_report_ok",    32'(report_ok), 32'd0);
        end
        check("bp_match_hold", 32'(match_count), 32'd29);
        in_valid     = 1'b0;
        report_ready = 1'b1;
        @(posedge clock); #1;
        report_ready = 1'b0;
        check("bp_valid_drop",   32'(report_valid), 32'd0);
        check("bp_in_ready",     32'(in_ready), 32'd1);
        check("bp_bad_cleared",  32'(report_bad), 32'd0);

        // Clear coinciding with a mismatching accept
        clear = 1'b1;
        send(8'h10, 8'd3);
        check("clr_match",    32'(match_count), 32'd0);
        check("clr_mismatch", 32'(mismatch_count), 32'd0);
        check("clr_sticky",   32'(sticky_err), 32'd0);
        for (int i = 0; i < 7; i++) send(8'd3, 8'd3);
        check("clr_report_valid", 32'(report_valid), 32'd1);
        check("clr_report_ok",    32'(report_ok), 32'd0);
        check("clr_report_bad",   32'(report_bad), 32'h10);
        check("clr_match_after",  32'(match_count), 32'd14);
        check("clr_sticky_after", 32'(sticky_err), 32'd0);
        report_ready = 1'b1;
        @(posedge clock); #1;
        report_ready = 1'b0;

        // Asynchronous reset while a report is pending
        for (int i = 0; i < 8; i++) send(8'd3, 8'd3);
        check("ar_report_valid", 32'(report_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_valid_drop", 32'(report_valid), 32'd0);
        check("ar_in_ready",   32'(in_ready), 32'd1);
        check("ar_match_zero", 32'(match_count), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        check("ar_in_ready_post", 32'(in_ready), 32'd1);
        check("ar_valid_post",    32'(report_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
